instruction_fetch_ctrl: RTL and testbench
=========================================

// Module: instruction_fetch_ctrl
// PURPOSE
//  PC sequencer for the 128-word combinational instruction memory: drives ImemAddr, captures ImemInstr
//  into a registered IF/ID slot with valid/ready handshake, applies branch/jump redirects, supports halt.
//  Sits between instruction memory and the decode stage of the MIPS pipeline.
// PARAMETERS
//  ADDR_W      32  PC / address width
//  RESET_PC    0   PC loaded on reset and on return to IDLE
//  IMEM_WORDS  128 instruction memory depth in words; used only by the range check
// PORTS
//  Clk             in   1       clock, rising edge
//  Rst_n           in   1       asynchronous, active-low reset
//  Start           in   1       IDLE->RUN request
//  HaltReq         in   1       stop fetching after the current slot drains
//  RedirValid      in   1       taken branch/jump/jr this cycle
//  RedirTarget     in   ADDR_W  redirect byte address
//  ImemAddr        out  ADDR_W  address to instruction memory (= PC, combinational from PC reg)
//  ImemInstr       in   32      instruction memory read data, valid same cycle
//  IfIdValid       out  1       IF/ID slot holds a live instruction
//  IfIdReady       in   1       decode accepts slot this cycle
//  IfIdInstr       out  32      captured instruction
//  IfIdPc4         out  ADDR_W  captured PC+4
//  AlignErr        out  1       sticky: a redirect target had [1:0]!=0
//  FetchCount      out  32      instructions accepted by decode since reset
//  State           out  2       IDLE=0 RUN=1 HALTED=2 FAULT=3
// BEHAVIOUR
//  Reset (async, Rst_n=0): PC=RESET_PC, State=IDLE, IfIdValid=0, IfIdInstr=0, IfIdPc4=0, AlignErr=0,
//   FetchCount=0. Release synchronous to Clk; first fetch is no earlier than the 2nd edge after release.
//  IDLE: no capture; Start=1 -> RUN next edge.
//  RUN, each edge, priority order:
//   1 RedirValid: PC<=RedirTarget with [1:0] forced 00; IfIdValid<=0 (squash, even if Ready=1 — count
//     still increments if Valid&Ready); AlignErr|=|RedirTarget[1:0].
//   2 HaltReq: no new capture; State->HALTED once IfIdValid=0 or the slot is accepted this edge.
//   3 slot free (IfIdValid=0 or IfIdReady=1): IfIdInstr<=ImemInstr, IfIdPc4<=PC+4, IfIdValid<=1, PC<=PC+4.
//   4 else (Valid & !Ready): hold PC and slot unchanged (no loss, no duplicate).
//  Throughput: one instruction per cycle with Ready held 1; fetch latency 1 edge (PC -> IfIdInstr).
//  FetchCount increments on every edge with IfIdValid&IfIdReady; wraps 2^32-1 -> 0.
//  PC arithmetic modulo 2^ADDR_W; PC=FFFF_FFFC +4 -> 0, no flag.
//  HALTED: PC frozen, IfIdValid=0; Start=1 -> PC<=RESET_PC, State->RUN. Redirect ignored.
//  Rst_n low mid-operation: everything returns to reset values immediately, in-flight slot discarded.
// CONFIGURATION
//  FETCH_RANGE_CHECK_EN defined: in RUN, if PC[ADDR_W-1:2] >= IMEM_WORDS at capture time, no capture,
//   State->FAULT (sticky until reset), IfIdValid<=0; a redirect out of range faults the next cycle.
//  Undefined: no check; addresses alias modulo memory depth (memory decodes bits [8:2]); FAULT unreachable.
// STRUCTURE
//  Shared package fetch_pkg: state encoding constants (ST_IDLE..ST_FAULT), NOP=32'h0, PC_STEP=4.
//  One sub-module natural: ifid_slot (one-entry registered buffer with valid/ready, squash, hold).
//  Controller FSM and PC register stay in instruction_fetch_ctrl.
// TESTING
//  T1 reset then Start, Ready=1, memory[i]=i*3: IfIdInstr 0,3,6,... on consecutive edges, IfIdPc4 4,8,12.
//  T2 Ready=0 for 3 cycles at PC=0x10: IfIdInstr held = mem[3]; PC stays 0x10; resumes mem[4], no dup/loss.
//  T3 RedirValid target 0x08 with slot valid: slot squashed, next captured = mem[2], PC4=0x0C; AlignErr=0.
//  T4 RedirTarget 0x0000_0013: PC=0x10, AlignErr=1 and stays 1 after later aligned redirects.
//  T5 HaltReq with Ready=0 then Ready=1: HALTED only after acceptance, FetchCount exact; Start -> PC=0.
//  T6 Rst_n pulse low mid-RUN (async, between edges): outputs reset immediately; with FETCH_RANGE_CHECK_EN,
//     redirect to 0x200 -> State=FAULT, IfIdValid=0 thereafter.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding and fetch constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0;
    localparam int          PC_STEP = 4;

endpackage

// File: rtl/ifid_slot.sv
// One-entry registered IF/ID buffer with valid/ready handshake, squash and hold.
module ifid_slot
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              squash,
    input  logic              ready,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc4_in,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    // Squash only drops valid; the stale payload is never observed while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP;
            pc4   <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc4   <= pc4_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// PC sequencer and fetch FSM feeding the IF/ID slot.
// Optional fetch address range check enabled by defining FETCH_RANGE_CHECK_EN.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                IMEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              ifid_valid,
    input  logic              ifid_ready,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              align_err,
    output logic [31:0]       fetch_count,
    output logic [1:0]        state
);

`ifdef FETCH_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [ADDR_W-3:0] IMEM_LIMIT = (ADDR_W-2)'(IMEM_WORDS);

    fetch_state_e      state_q, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next, pc_plus4;
    logic              align_err_q, align_err_next;
    logic              capture, squash, slot_free, range_fault;

    assign pc_plus4    = pc_q + ADDR_W'(PC_STEP);
    assign slot_free   = !ifid_valid || ifid_ready;
    assign range_fault = RANGE_CHECK && (pc_q[ADDR_W-1:2] >= IMEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q     <= state_next;
            pc_q        <= pc_next;
            align_err_q <= align_err_next;
            if (ifid_valid && ifid_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    // Within RUN: redirect beats halt beats capture; a blocked slot simply holds.
    always_comb begin
        state_next     = state_q;
        pc_next        = pc_q;
        align_err_next = align_err_q;
        capture        = 1'b0;
        squash         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redir_valid) begin
                    pc_next = {redir_target[ADDR_W-1:2], 2'b00};
                    squash  = 1'b1;
                    if (|redir_target[1:0]) align_err_next = 1'b1;
                end else if (halt_req) begin
                    if (slot_free) state_next = ST_HALTED;
                end else if (slot_free) begin
                    if (range_fault) begin
                        state_next = ST_FAULT;
                        squash     = 1'b1;
                    end else begin
                        capture = 1'b1;
                        pc_next = pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                if (start) begin
                    pc_next    = RESET_PC;
                    state_next = ST_RUN;
                end
            end
            ST_FAULT: begin
            end
        endcase
    end

    ifid_slot #(.ADDR_W(ADDR_W)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .squash   (squash),
        .ready    (ifid_ready),
        .instr_in (imem_instr),
        .pc4_in   (pc_plus4),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4)
    );

    assign imem_addr = pc_q;
    assign align_err = align_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench for instruction_fetch_ctrl: directed scenarios then random traffic vs a reference model.
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, redir_valid, ifid_ready;
    logic [31:0] redir_target, imem_addr, imem_instr, ifid_instr, ifid_pc4, fetch_count;
    logic        ifid_valid, align_err;
    logic [1:0]  state;

    logic [31:0] mem [128];

    int passed = 0;
    int total  = 0;

    // reference model: architectural view of the fetch unit after each edge
    logic [1:0]  m_state;
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_v, m_err;

`ifdef FETCH_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    instruction_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .ifid_valid   (ifid_valid),
        .ifid_ready   (ifid_ready),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .align_err    (align_err),
        .fetch_count  (fetch_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[8:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0;
        m_pc4 = 32'h0; m_err = 1'b0; m_cnt = 32'h0;
    endtask

    // Apply the fetch rules for one rising edge given the inputs currently driven.
    task automatic model_edge();
        bit accepted, free;
        accepted = m_v && ifid_ready;
        free     = !m_v || ifid_ready;
        if (accepted) m_cnt = m_cnt + 1;
        case (m_state)
            2'd0: if (start) m_state = 2'd1;
            2'd1: begin
                if (redir_valid) begin
                    m_pc  = redir_target & ~32'h3;
                    m_v   = 1'b0;
                    m_err = m_err | (redir_target[1:0] != 2'b00);
                end else if (halt_req) begin
                    if (free) begin
                        m_v     = 1'b0;
                        m_state = 2'd2;
                    end
                end else if (free) begin
                    if (RC && (m_pc / 4 >= 128)) begin
                        m_v     = 1'b0;
                        m_state = 2'd3;
                    end else begin
                        m_instr = mem[(m_pc / 4) % 128];
                        m_pc4   = m_pc + 4;
                        m_v     = 1'b1;
                        m_pc    = m_pc + 4;
                    end
                end
            end
            2'd2: if (start) begin
                m_pc    = 32'h0;
                m_state = 2'd1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string where);
        chk({where, ".state"}, {30'b0, state}, {30'b0, m_state});
        chk({where, ".pc"}, imem_addr, m_pc);
        chk({where, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_v});
        if (m_v) begin
            chk({where, ".instr"}, ifid_instr, m_instr);
            chk({where, ".pc4"}, ifid_pc4, m_pc4);
        end
        chk({where, ".align"}, {31'b0, align_err}, {31'b0, m_err});
        chk({where, ".count"}, fetch_count, m_cnt);
    endtask

    // Called at a falling edge: drive inputs, advance model, cross the rising edge, compare.
    task automatic cyc(input string where, input bit st, input bit hr, input bit rv,
                       input logic [31:0] rt, input bit rdy);
        start = st; halt_req = hr; redir_valid = rv; redir_target = rt; ifid_ready = rdy;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(where);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".state"}, {30'b0, state}, 32'd0);
        chk({where, ".pc"}, imem_addr, 32'h0);
        chk({where, ".valid"}, {31'b0, ifid_valid}, 32'd0);
        chk({where, ".instr"}, ifid_instr, 32'h0);
        chk({where, ".pc4"}, ifid_pc4, 32'h0);
        chk({where, ".align"}, {31'b0, align_err}, 32'd0);
        chk({where, ".count"}, fetch_count, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = i * 3;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;
        redir_target = 32'h0; ifid_ready = 1'b0;
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: start and stream with ready held high
        cyc("t1_start", 1, 0, 0, 0, 1);
        chk("t1_idle_no_capture", {31'b0, ifid_valid}, 32'd0);
        cyc("t1_f0", 0, 0, 0, 0, 1);
        chk("t1_instr0", ifid_instr, 32'd0);
        chk("t1_pc4_0", ifid_pc4, 32'd4);
        cyc("t1_f1", 0, 0, 0, 0, 1);
        chk("t1_instr1", ifid_instr, 32'd3);
        chk("t1_pc4_1", ifid_pc4, 32'd8);
        cyc("t1_f2", 0, 0, 0, 0, 1);
        chk("t1_instr2", ifid_instr, 32'd6);
        cyc("t1_f3", 0, 0, 0, 0, 1);

        // T2: decode stalls three cycles with PC at 0x10
        for (int i = 0; i < 3; i++) begin
            cyc("t2_stall", 0, 0, 0, 0, 0);
            chk("t2_hold_instr", ifid_instr, 32'd9);
            chk("t2_hold_pc", imem_addr, 32'h10);
        end
        cyc("t2_resume", 0, 0, 0, 0, 1);
        chk("t2_next_instr", ifid_instr, 32'd12);
        chk("t2_count", fetch_count, 32'd4);

        // T3: aligned redirect squashes a live slot even though it is accepted
        cyc("t3_redir", 0, 0, 1, 32'h08, 1);
        chk("t3_squash", {31'b0, ifid_valid}, 32'd0);
        chk("t3_count", fetch_count, 32'd5);
        cyc("t3_cap", 0, 0, 0, 0, 1);
        chk("t3_instr", ifid_instr, 32'd6);
        chk("t3_pc4", ifid_pc4, 32'h0C);
        chk("t3_align", {31'b0, align_err}, 32'd0);

        // T4: unaligned redirect sets the sticky flag
        cyc("t4_unaligned", 0, 0, 1, 32'h13, 1);
        chk("t4_pc", imem_addr, 32'h10);
        chk("t4_align", {31'b0, align_err}, 32'd1);
        cyc("t4_aligned", 0, 0, 1, 32'h20, 0);
        chk("t4_sticky", {31'b0, align_err}, 32'd1);

        // T5: halt waits for the slot to be accepted, start restarts from 0
        cyc("t5_fill", 0, 0, 0, 0, 0);
        cyc("t5_halt_blk", 0, 1, 0, 0, 0);
        chk("t5_not_halted", {30'b0, state}, 32'd1);
        cyc("t5_halt_blk2", 0, 1, 0, 0, 0);
        cyc("t5_halt_acc", 0, 1, 0, 0, 1);
        chk("t5_halted", {30'b0, state}, 32'd2);
        cyc("t5_redir_ign", 0, 0, 1, 32'h40, 1);
        chk("t5_pc_frozen", imem_addr, 32'h24);
        cyc("t5_restart", 1, 0, 0, 0, 1);
        chk("t5_restart_pc", imem_addr, 32'h0);

`ifndef FETCH_RANGE_CHECK_EN
        // PC wraps at the top of the address space without a flag
        cyc("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC, 1);
        cyc("wrap_cap", 0, 0, 0, 0, 1);
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
`endif

        // random traffic over randomized memory contents
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tgt;
            tgt = $urandom_range(0, 32'h1FF);
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cyc("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 7);
        end

        // T6: asynchronous reset between edges
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc("t6_run", i == 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t6_start", 1, 0, 0, 0, 1);
        cyc("t6_fetch", 0, 0, 0, 0, 1);
        cyc("t6_far", 0, 0, 1, 32'h200, 1);
        cyc("t6_after", 0, 0, 0, 0, 1);
        chk("t6_far_state", {30'b0, state}, RC ? 32'd3 : 32'd1);
        chk("t6_far_valid", {31'b0, ifid_valid}, RC ? 32'd0 : 32'd1);
        for (int i = 0; i < 3; i++) cyc("t6_tail", 1, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
